keyed_prio_intc: RTL and testbench

Parametrised, key-locked priority interrupt controller; sequential successor to the combinational c432-class 27-channel priority decoder. Per-channel requests pass through a key-gate layer (XOR key gates on selected channels, one 4-input mux LUT key gate), get latched as pending, and are priority-encoded into a registered valid/id/ack handshake toward the CPU-side interrupt port. The key is loaded serially at runtime, so the controller behaves correctly only after the correct key is committed.

---
 rtl/keyed_intc_pkg.sv | 24 ++
 rtl/keyed_prio_enc.sv | 23 ++
 rtl/keyed_prio_intc.sv | 123 ++++++++++++
 tb/tb_keyed_prio_intc.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/keyed_intc_pkg.sv
// rtl/keyed_intc_pkg.sv - shared types, key layout and helpers for the keyed interrupt controller
package keyed_intc_pkg;

    typedef enum logic {
        KEY_LOCKED = 1'b0,
        KEY_ARMED  = 1'b1
    } key_state_e;

    // Key word is {lut[3:0], xor_key[XOR_KEYS-1:0]}
    localparam int KEY_XOR_LSB = 0;
    localparam int KEY_LUT_W   = 4;

    localparam logic [3:0] CORRECT_LUT         = 4'b0100;
    localparam logic [5:0] CORRECT_KEY_DEFAULT = {CORRECT_LUT, 2'b11};

    function automatic int key_lut_lsb(input int xor_keys);
        return xor_keys;
    endfunction

    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/keyed_prio_enc.sv
// rtl/keyed_prio_enc.sv - combinational lowest-index-first priority encoder
module keyed_prio_enc #(
    parameter int NUM_CH = 27,
    parameter int ID_W   = 5
) (
    input  logic [NUM_CH-1:0] req_i,
    output logic              valid_o,
    output logic [ID_W-1:0]   id_o
);

    // Scan downward so the lowest set index is the last one written
    always_comb begin
        valid_o = 1'b0;
        id_o    = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (req_i[c]) begin
                valid_o = 1'b1;
                id_o    = ID_W'(c);
            end
        end
    end

endmodule

// File: rtl/keyed_prio_intc.sv
// rtl/keyed_prio_intc.sv - key-locked priority interrupt controller with registered valid/id/ack port
module keyed_prio_intc
    import keyed_intc_pkg::*;
#(
    parameter int                NUM_CH    = 27,
    parameter int                XOR_KEYS  = 2,
    parameter logic [NUM_CH-1:0] LOCK_MASK = NUM_CH'(27'h0000108),
    parameter int                MUX_CH    = 6,
    localparam int               KEY_W     = XOR_KEYS + 4,
    localparam int               ID_W      = id_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              mask_we,
    input  logic [NUM_CH-1:0] mask_in,
    input  logic              key_in,
    input  logic              key_shift,
    input  logic              key_commit,
    output logic              irq_valid,
    output logic [ID_W-1:0]   irq_id,
    input  logic              irq_ack,
    output logic              key_armed
);

    key_state_e              state_q;
    logic                    key_armed_q;
    logic [KEY_W-1:0]        shift_q;
    logic [KEY_W-1:0]        key_q;
    logic [NUM_CH-1:0]       mask_q;
    logic [NUM_CH-1:0]       pend_q;
    logic [NUM_CH-1:0]       pend_d;
    logic [NUM_CH-1:0]       eff;
    logic [NUM_CH-1:0]       clr;
    logic [NUM_CH-1:0]       enc_in;
    logic                    irq_valid_q;
    logic [ID_W-1:0]         irq_id_q;
    logic                    enc_valid;
    logic [ID_W-1:0]         enc_id;
    logic                    ack_fire;
    logic [XOR_KEYS-1:0]     xor_key;
    logic [KEY_LUT_W-1:0]    lut;

    assign xor_key = key_q[KEY_XOR_LSB +: XOR_KEYS];
    assign lut     = key_q[key_lut_lsb(XOR_KEYS) +: KEY_LUT_W];

    // Key-gate layer works on raw pins; a wrong key corrupts which channels look active
    always_comb begin
        eff = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (c == MUX_CH)
                eff[c] = lut[{req[c], mask_q[c]}];
            else if (LOCK_MASK[c])
                eff[c] = (req[c] ^ xor_key[c % XOR_KEYS]) & ~mask_q[c];
            else
                eff[c] = req[c] & ~mask_q[c];
        end
    end

    assign ack_fire = irq_ack & irq_valid_q;
    assign clr      = ack_fire ? (NUM_CH'(1) << irq_id_q) : '0;
    assign pend_d   = (pend_q & ~clr) | eff;
    // The acked channel is excluded from this cycle's pick even if it re-sets
    assign enc_in   = pend_q & ~clr;

    keyed_prio_enc #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_enc (
        .req_i   (enc_in),
        .valid_o (enc_valid),
        .id_o    (enc_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q      <= '1;
            pend_q      <= '0;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
        end else begin
            if (mask_we)
                mask_q <= mask_in;
            pend_q <= pend_d;
            if (!irq_valid_q || ack_fire) begin
                irq_valid_q <= enc_valid;
                irq_id_q    <= enc_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= KEY_LOCKED;
            key_armed_q <= 1'b0;
            shift_q     <= '0;
            key_q       <= '0;
        end else begin
            if (key_shift)
                shift_q <= {shift_q[KEY_W-2:0], key_in};
            case (state_q)
                KEY_LOCKED: if (key_commit) begin
                    key_q       <= shift_q;
                    state_q     <= KEY_ARMED;
                    key_armed_q <= 1'b1;
                end
                KEY_ARMED: if (key_commit) begin
                    key_q       <= shift_q;
                    key_armed_q <= 1'b1;
                end
                default: begin
                    state_q     <= KEY_LOCKED;
                    key_armed_q <= 1'b0;
                end
            endcase
        end
    end

    assign irq_valid = irq_valid_q;
    assign irq_id    = irq_id_q;
    assign key_armed = key_armed_q;

endmodule

// File: tb/tb_keyed_prio_intc.sv
// tb/tb_keyed_prio_intc.sv - directed self-checking bench for keyed_prio_intc
module tb_keyed_prio_intc;

    localparam int          NUM_CH = 27;
    localparam int          ID_W   = 5;
    localparam logic [26:0] IDLE   = 27'h0000108;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] req;
    logic              mask_we;
    logic [NUM_CH-1:0] mask_in;
    logic              key_in;
    logic              key_shift;
    logic              key_commit;
    logic              irq_valid;
    logic [ID_W-1:0]   irq_id;
    logic              irq_ack;
    logic              key_armed;

    int n_pass  = 0;
    int n_total = 0;
    int exp_q[$];

    keyed_prio_intc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .mask_we    (mask_we),
        .mask_in    (mask_in),
        .key_in     (key_in),
        .key_shift  (key_shift),
        .key_commit (key_commit),
        .irq_valid  (irq_valid),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .key_armed  (key_armed)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_irq(input string tag);
        int n;
        int exp_id;
        n = 0;
        while (!irq_valid && n < 4) begin
            step();
            n++;
        end
        exp_id = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        chk({tag, "_valid"}, 32'(irq_valid), 32'd1);
        chk({tag, "_id"}, 32'(irq_id), 32'(exp_id));
    endtask

    task automatic load_key(input logic [5:0] k);
        for (int i = 5; i >= 0; i--) begin
            key_in    = k[i];
            key_shift = 1'b1;
            step();
        end
        key_shift  = 1'b0;
        key_commit = 1'b1;
        step();
        key_commit = 1'b0;
    endtask

    task automatic set_mask(input logic [NUM_CH-1:0] m);
        mask_in = m;
        mask_we = 1'b1;
        step();
        mask_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = IDLE; mask_we = 1'b0; mask_in = '0;
        key_in = 1'b0; key_shift = 1'b0; key_commit = 1'b0; irq_ack = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_valid", 32'(irq_valid), 32'd0);
        chk("rst_id", 32'(irq_id), 32'd0);
        chk("rst_armed", 32'(key_armed), 32'd0);

        // Zero key: idle-high locked ch3 reads as asserted
        mask_in = '0; mask_we = 1'b1;
        step();
        mask_we = 1'b0;
        exp_q.push_back(3);
        step();
        chk("nokey_latency", 32'(irq_valid), 32'd0);
        step();
        check_irq("nokey_ch3");

        // Correct key committed before unmasking: idle pins stay quiet
        do_reset();
        load_key(6'b010011);
        set_mask('0);
        step();
        step();
        chk("key_armed", 32'(key_armed), 32'd1);
        chk("key_idle_valid", 32'(irq_valid), 32'd0);
        req[8] = 1'b0;
        step();
        req[8] = 1'b1;
        chk("ch8_latency", 32'(irq_valid), 32'd0);
        exp_q.push_back(8);
        step();
        check_irq("ch8");
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("ch8_done", 32'(irq_valid), 32'd0);

        // Two simultaneous requests served lowest first, one per cycle
        req[5] = 1'b1; req[20] = 1'b1;
        exp_q.push_back(5);
        exp_q.push_back(20);
        step();
        req = IDLE;
        step();
        check_irq("pair_first");
        irq_ack = 1'b1;
        step();
        check_irq("pair_second");
        step();
        irq_ack = 1'b0;
        chk("pair_empty", 32'(irq_valid), 32'd0);

        // No preemption of a presented interrupt
        req[20] = 1'b1;
        step();
        req = IDLE;
        step();
        exp_q.push_back(20);
        check_irq("hold_20");
        req[1] = 1'b1;
        step();
        req = IDLE;
        step();
        step();
        chk("nopreempt_id", 32'(irq_id), 32'd20);
        irq_ack = 1'b1;
        exp_q.push_back(1);
        step();
        check_irq("after_ack_1");
        step();
        irq_ack = 1'b0;
        chk("preempt_empty", 32'(irq_valid), 32'd0);

        // Mux-gated channel: masked request ignored with correct key
        set_mask(27'h0000040);
        req[6] = 1'b1;
        step();
        step();
        step();
        chk("ch6_masked", 32'(irq_valid), 32'd0);
        // Wrong lut 1000: masked+requesting now pends
        load_key(6'b100011);
        chk("ch6_commit_edge", 32'(irq_valid), 32'd0);
        exp_q.push_back(6);
        step();
        check_irq("ch6_wronglut");
        req[6] = 1'b0;
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("ch6_cleared", 32'(irq_valid), 32'd0);

        // Async reset while serving
        load_key(6'b010011);
        set_mask('0);
        req[2] = 1'b1; req[9] = 1'b1;
        step();
        req = IDLE;
        step();
        exp_q.push_back(2);
        check_irq("pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(irq_valid), 32'd0);
        chk("async_id", 32'(irq_id), 32'd0);
        chk("async_armed", 32'(key_armed), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        step();
        chk("post_reset_valid", 32'(irq_valid), 32'd0);
        chk("post_reset_armed", 32'(key_armed), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
